// File: rtl/led_pwm_breathe.sv
// Multi-channel breathing LED PWM driver: triangle brightness ramp, per-channel phase offset.
// Optional build macro LED_GAMMA_EN squares each channel duty (approx. gamma 2.0).
module led_pwm_breathe #(
    parameter int CHANNELS     = 8,
    parameter int PWM_BITS     = 8,
    parameter int STEP_PERIODS = 4,
    parameter int PHASE_STEP   = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                en_i,
    output logic [CHANNELS-1:0] led_o,
    output logic [PWM_BITS-1:0] level_o,
    output logic                dir_o,
    output logic                period_o
);

    localparam logic [PWM_BITS-1:0] MAX       = '1;
    localparam logic [PWM_BITS-1:0] LVL_TOP   = MAX - PWM_BITS'(1);
    localparam logic [PWM_BITS-1:0] LVL_BOT   = PWM_BITS'(1);
    localparam int                  SCW       = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
    localparam logic [SCW-1:0]      STEP_LAST = SCW'(STEP_PERIODS - 1);

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } ramp_e;

    function automatic logic [PWM_BITS-1:0] shape(input logic [PWM_BITS-1:0] d);
`ifdef LED_GAMMA_EN
        logic [2*PWM_BITS-1:0] sq;
        sq = {{PWM_BITS{1'b0}}, d} * {{PWM_BITS{1'b0}}, d};
        return sq[2*PWM_BITS-1:PWM_BITS];
`else
        return d;
`endif
    endfunction

    logic [PWM_BITS-1:0] pwm_cnt;
    logic [SCW-1:0]      step_cnt;
    logic [PWM_BITS-1:0] level;
    ramp_e               state;
    logic [PWM_BITS-1:0] duty_q [CHANNELS];
    logic [PWM_BITS-1:0] duty_d [CHANNELS];
    logic [CHANNELS-1:0] led_d;
    logic                period_end;
    logic                step;

    assign period_end = en_i && (pwm_cnt == MAX);
    assign step       = period_end && (step_cnt == STEP_LAST);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        led_d = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            duty_d[k] = shape(level + PWM_BITS'(k * PHASE_STEP));
            led_d[k]  = en_i && (pwm_cnt < duty_q[k]);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values; this is what gives duty_q the pre-step level.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pwm_cnt  <= '0;
            step_cnt <= '0;
            level    <= '0;
            state    <= UP;
            led_o    <= '0;
            period_o <= 1'b0;
            // NOTE: the duty bank is a handful of flops, not a RAM, so it is reset
            // along with everything else; LEDs must be dark straight out of reset.
            for (int k = 0; k < CHANNELS; k++) begin
                duty_q[k] <= '0;
            end
        end else begin
            led_o    <= led_d;
            period_o <= period_end;

            if (en_i) begin
                pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            end

            if (period_end) begin
                step_cnt <= step ? '0 : step_cnt + SCW'(1);
                for (int k = 0; k < CHANNELS; k++) begin
                    duty_q[k] <= duty_d[k];
                end
            end

            // Direction flips on the same step that reaches the end point.
            if (step) begin
                case (state)
                    UP: begin
                        level <= level + PWM_BITS'(1);
                        if (level == LVL_TOP) state <= DOWN;
                    end
                    DOWN: begin
                        level <= level - PWM_BITS'(1);
                        if (level == LVL_BOT) state <= UP;
                    end
                    default: state <= UP;
                endcase
            end
        end
    end

    assign level_o = level;
    assign dir_o   = (state == DOWN);

endmodule

// File: tb/tb_led_pwm_breathe.sv
// Self-checking bench for led_pwm_breathe: closed-form ramp model plus directed literal checks.
// Two 4-bit instances: A (STEP_PERIODS=1, 2 ch, phase 8), B (STEP_PERIODS=3, 4 ch, phase 5).
module tb_led_pwm_breathe;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic [1:0] led_a;
    logic [3:0] led_b;
    logic [3:0] level_a, level_b;
    logic       dir_a, dir_b, period_a, period_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    led_pwm_breathe #(.CHANNELS(2), .PWM_BITS(4), .STEP_PERIODS(1), .PHASE_STEP(8)) dut_a (
        .clk_i(clk), .rst_i(rst), .en_i(en),
        .led_o(led_a), .level_o(level_a), .dir_o(dir_a), .period_o(period_a)
    );

    led_pwm_breathe #(.CHANNELS(4), .PWM_BITS(4), .STEP_PERIODS(3), .PHASE_STEP(5)) dut_b (
        .clk_i(clk), .rst_i(rst), .en_i(en),
        .led_o(led_b), .level_o(level_b), .dir_o(dir_b), .period_o(period_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: everything follows from e, the number of enabled clock edges since reset.
    function automatic int ramp_level(input int s);
        int r;
        r = s % 30;
        return (r <= 15) ? r : 30 - r;
    endfunction

    function automatic int ramp_dir(input int s);
        return ((s % 30) >= 15) ? 1 : 0;
    endfunction

    function automatic int shape_m(input int d);
`ifdef LED_GAMMA_EN
        return (d * d) >> 4;
`else
        return d;
`endif
    endfunction

    // Duty in force while the pwm counter sits in period e/16; it holds the
    // level that was current just before the previous period ended.
    function automatic int model_duty(input int e_now, input int sp, input int k, input int ph);
        int p;
        p = e_now / 16;
        if (p == 0) return 0;
        return shape_m((ramp_level((p - 1) / sp) + k * ph) % 16);
    endfunction

    int         e = 0;
    logic [1:0] exp_led_a = '0;
    logic [3:0] exp_led_b = '0;
    logic       exp_per   = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            e         <= 0;
            exp_led_a <= '0;
            exp_led_b <= '0;
            exp_per   <= 1'b0;
        end else if (en) begin
            for (int k = 0; k < 2; k++) exp_led_a[k] <= ((e % 16) < model_duty(e, 1, k, 8));
            for (int k = 0; k < 4; k++) exp_led_b[k] <= ((e % 16) < model_duty(e, 3, k, 5));
            exp_per <= ((e % 16) == 15);
            e       <= e + 1;
        end else begin
            exp_led_a <= '0;
            exp_led_b <= '0;
            exp_per   <= 1'b0;
        end
    end

    always @(negedge clk) begin
        check("led_a",    led_a,    exp_led_a);
        check("level_a",  level_a,  ramp_level(e / 16));
        check("dir_a",    dir_a,    ramp_dir(e / 16));
        check("period_a", period_a, exp_per);
        check("led_b",    led_b,    exp_led_b);
        check("level_b",  level_b,  ramp_level((e / 16) / 3));
        check("dir_b",    dir_b,    ramp_dir((e / 16) / 3));
        check("period_b", period_b, exp_per);
    end

    task automatic wait_e(input int target);
        int guard;
        guard = 0;
        while (e != target && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        check("wait_budget", e, target);
    endtask

    task automatic count_led_a(input int ch, output int c);
        c = 0;
        repeat (16) begin
            @(negedge clk);
            c += int'(led_a[ch]);
        end
    endtask

    int c;
    int n;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_led_a",  led_a,    0);
        check("rst_level",  level_a,  0);
        check("rst_dir",    dir_a,    0);
        check("rst_period", period_a, 0);
        rst = 1'b0;
        en  = 1'b1;

        wait_e(16);
        check("lvl_first_step", level_a, 1);
        check("lvl_b_no_step",  level_b, 0);
        wait_e(32);
        count_led_a(0, c);
`ifdef LED_GAMMA_EN
        check("duty1_cycles", c, 0);
`else
        check("duty1_cycles", c, 1);
`endif
        wait_e(48);
        check("lvl_b_first_step", level_b, 1);

        wait_e(144);
        count_led_a(0, c);
`ifdef LED_GAMMA_EN
        check("duty8_cycles", c, 4);
`else
        check("duty8_cycles", c, 8);
`endif
        wait_e(208);
        count_led_a(1, c);
`ifdef LED_GAMMA_EN
        check("phase_wrap_cycles", c, 1);
`else
        check("phase_wrap_cycles", c, 4);
`endif

        wait_e(240);
        check("lvl_top", level_a, 15);
        check("dir_top", dir_a, 1);
        wait_e(256);
        check("lvl_after_top", level_a, 14);
        check("dir_after_top", dir_a, 1);
        wait_e(480);
        check("lvl_bottom", level_a, 0);
        check("dir_bottom", dir_a, 0);

        // Hold with the pwm counter parked at 5.
        wait_e(485);
        en = 1'b0;
        @(negedge clk);
        check("hold_led_a", led_a, 0);
        check("hold_led_b", led_b, 0);
        repeat (99) @(negedge clk);
        check("hold_level_a", level_a, 0);
        check("hold_level_b", level_b, 10);
        en = 1'b1;
        n  = 0;
        do begin
            @(negedge clk);
            n++;
        end while (period_a !== 1'b1 && n < 40);
        check("resume_to_period", n, 11);

        repeat (2000) begin
            @(negedge clk);
            en = ($urandom_range(0, 3) != 0);
        end
        en = 1'b1;
        repeat (20) @(negedge clk);

        // Reset pulse between edges must clear outputs without a clock.
        #1 rst = 1'b1;
        #1;
        check("async_led_a",  led_a,    0);
        check("async_led_b",  led_b,    0);
        check("async_level",  level_a,  0);
        check("async_levelb", level_b,  0);
        check("async_dir",    dir_a,    0);
        check("async_period", period_a, 0);
        #1 rst = 1'b0;
        repeat (50) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
